fifo_arbiter: RTL and testbench
===============================

FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of write requesters, 2..8.
REQ-002 Parameter DW, default 8: data width per requester.
REQ-003 Parameter BURST, default 4: maximum consecutive writes per grant, 1..15.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 req  in  NREQ  write request, one bit per requester; level, held until serviced.
REQ-007 wr_data_in  in  NREQ*DW  requester data; slice i = bits [i*DW +: DW].
REQ-008 full  in  1  FIFO full flag.
REQ-009 empty  in  1  FIFO empty flag.
REQ-010 rd_req  in  1  consumer read request.
REQ-011 gnt  out  NREQ  one-hot write acknowledge; requester data consumed in that cycle.
REQ-012 wr_strobe  out  1  FIFO write strobe.
REQ-013 wr_data  out  DW  data muxed from the granted requester.
REQ-014 rd_strobe  out  1  FIFO read strobe.
REQ-015 rd_valid  out  1  FIFO read data valid.
REQ-016 busy  out  1  high while a burst owner is held.

Function
REQ-017 Registered state: state (IDLE/OWN), owner index, burst count cnt (4 bits), round-robin pointer ptr.
REQ-018 gnt, wr_strobe and wr_data shall be combinational from registered state plus req and full; zero-latency acknowledge.
REQ-019 wr_strobe shall equal |gnt; at most one gnt bit high per cycle.
REQ-020 When wr_strobe=0, wr_data shall be zero.
REQ-021 full=1 shall force gnt=0 and wr_strobe=0 with state, owner, cnt and ptr held (stall).
REQ-022 IDLE, full=0, any req: winner = first asserted req scanning ptr, ptr+1, ... modulo NREQ; grant winner; next state OWN, owner=winner, cnt=1.
REQ-023 IDLE, no req: no grant; state unchanged.
REQ-024 OWN, req[owner]=1, full=0: grant owner; cnt increments.
REQ-025 A write that brings cnt to BURST shall return state to IDLE with ptr=(owner+1) mod NREQ and cnt=0; the next cycle re-arbitrates with no idle gap.
REQ-026 BURST=1: the IDLE grant shall go straight back to IDLE with ptr=(winner+1) mod NREQ; state never enters OWN.
REQ-027 OWN, req[owner]=0: no grant that cycle; next state IDLE, ptr=(owner+1) mod NREQ, cnt=0.
REQ-028 Requests from non-owners during OWN shall be ignored until return to IDLE.
REQ-029 busy shall equal (state==OWN).
REQ-030 rd_strobe = rd_req & ~empty, combinational; independent of the write side.
REQ-031 rd_valid shall be rd_strobe registered by one cycle.

Reset
REQ-032 rst=0 shall immediately force state=IDLE, ptr=0, cnt=0, owner=0 and rd_valid=0.
REQ-033 While rst=0, gnt, wr_strobe, wr_data, rd_strobe and busy shall be 0, regardless of inputs.
REQ-034 Reset asserted mid-burst shall abandon the burst; first grant after release follows ptr=0.

Verification
REQ-035 All req=4'b1111 held, full=0, BURST=4: gnt = 0001 x4, 0010 x4, 0100 x4, 1000 x4, repeat; wr_strobe high every cycle.
REQ-036 Only req[1] held: four grants, one cycle back in IDLE with ptr=2, req[1] regranted in that same cycle; wr_strobe continuous; wr_data = slice 1.
REQ-037 req[0] burst, full=1 for 3 cycles after the 2nd write: gnt=0 and wr_strobe=0 for 3 cycles, busy=1; then exactly 2 more writes to req[0], then rotation.
REQ-038 req[0] drops after 2 writes, req[2] pending: one cycle with no grant, busy=1; next cycle gnt=0100.
REQ-039 rst pulsed low during the 3rd write of a req[3] burst with all req held: outputs 0 during reset; after release first gnt=0001.
REQ-040 rd_req=1 with empty=0 for 2 cycles, then empty=1: rd_strobe high 2 cycles, rd_valid high the following 2 cycles, then both 0.

Source files
------------

// File: rtl/fifo_arbiter.sv
// Round-robin burst arbiter feeding a shared FIFO write port,
// plus a pass-through read strobe with a registered valid.
module fifo_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] wr_data_in,
  input  logic               full,
  input  logic               empty,
  input  logic               rd_req,
  output logic [NREQ-1:0]    gnt,
  output logic               wr_strobe,
  output logic [DW-1:0]      wr_data,
  output logic               rd_strobe,
  output logic               rd_valid,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state_q;
  logic [PW-1:0] owner_q;
  logic [PW-1:0] ptr_q;
  logic [3:0]    cnt_q;
  logic          rd_valid_q;

  logic          found;
  logic [PW-1:0] win;
  logic [PW:0]   idx;
  logic          take;
  logic [PW-1:0] sel;
  logic [3:0]    cnt_nx;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(NREQ - 1)) ? '0 : p + PW'(1);
  endfunction

  // First asserted request at or after ptr, wrapping modulo NREQ
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(i);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    take = 1'b0;
    sel  = owner_q;
    if (rst && !full) begin
      if (state_q == IDLE) begin
        take = found;
        sel  = win;
      end else begin
        take = req[owner_q];
        sel  = owner_q;
      end
    end
  end

  assign gnt       = take ? (NREQ'(1) << sel) : '0;
  assign wr_strobe = take;
  assign wr_data   = take ? wr_data_in[int'(sel)*DW +: DW] : '0;
  assign rd_strobe = rst & rd_req & ~empty;
  assign rd_valid  = rd_valid_q;
  assign busy      = rst & (state_q == OWN);
  assign cnt_nx    = cnt_q + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_strobe;
      if (!full) begin
        unique case (state_q)
          IDLE: begin
            if (found) begin
              owner_q <= win;
              if (BURST == 1) begin
                ptr_q <= nxt(win);
              end else begin
                state_q <= OWN;
                cnt_q   <= 4'd1;
              end
            end
          end
          OWN: begin
            // Burst ends on the BURST-th write or when the owner lets go
            if (req[owner_q] && cnt_nx != 4'(BURST)) begin
              cnt_q <= cnt_nx;
            end else begin
              state_q <= IDLE;
              ptr_q   <= nxt(owner_q);
              cnt_q   <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter: directed scenarios plus random traffic
// against a queue-free ownership model of the arbitration rules.
module tb_fifo_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int B  = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] wdin;
  logic            full;
  logic            empty;
  logic            rd_req;
  logic [N-1:0]    gnt;
  logic            wr_strobe;
  logic [DW-1:0]   wr_data;
  logic            rd_strobe;
  logic            rd_valid;
  logic            busy;

  int checks = 0;
  int errors = 0;

  int m_own = -1;
  int m_cnt = 0;
  int m_ptr = 0;
  bit m_rdv = 0;

  fifo_arbiter #(.NREQ(N), .DW(DW), .BURST(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .wr_data_in (wdin),
    .full       (full),
    .empty      (empty),
    .rd_req     (rd_req),
    .gnt        (gnt),
    .wr_strobe  (wr_strobe),
    .wr_data    (wr_data),
    .rd_strobe  (rd_strobe),
    .rd_valid   (rd_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check, then advance the model
  task automatic cycle(input logic r, input logic [N-1:0] rq,
                       input logic f, input logic e,
                       input logic rr, input int dg);
    int w;
    logic [31:0] exp_d;
    rst    = r;
    req    = rq;
    full   = f;
    empty  = e;
    rd_req = rr;
    wdin   = $urandom;
    if (!r) begin
      m_own = -1;
      m_cnt = 0;
      m_ptr = 0;
      m_rdv = 0;
    end
    #1;
    w = -1;
    if (r && !f) begin
      if (m_own < 0) begin
        for (int k = 0; k < N; k++)
          if (w < 0 && rq[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end else if (rq[m_own]) begin
        w = m_own;
      end
    end
    exp_d = (w >= 0) ? 32'(wdin[w*DW +: DW]) : 32'd0;
    check("gnt", 32'(gnt), (w >= 0) ? (32'd1 << w) : 32'd0);
    check("wr_strobe", 32'(wr_strobe), 32'(w >= 0));
    check("wr_data", 32'(wr_data), exp_d);
    check("busy", 32'(busy), 32'(r && m_own >= 0));
    check("rd_strobe", 32'(rd_strobe), 32'(r & rr & ~e));
    check("rd_valid", 32'(rd_valid), 32'(m_rdv));
    if (dg >= 0) check("dir_gnt", 32'(gnt), 32'(dg));
    @(posedge clk);
    if (r) begin
      m_rdv = rr & ~e;
      if (!f) begin
        if (w >= 0) begin
          if (m_own < 0) begin
            m_own = w;
            m_cnt = 0;
          end
          m_cnt++;
        end
        if (m_own >= 0 && (w < 0 || m_cnt == B)) begin
          m_ptr = (m_own + 1) % N;
          m_own = -1;
          m_cnt = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    cycle(0, N'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
    cycle(0, N'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
  endtask

  initial begin
    int seq37 [11] = '{1, 1, 0, 0, 0, 1, 1, 2, 2, 2, 2};
    clk    = 0;
    rst    = 1;
    req    = '0;
    wdin   = '0;
    full   = 0;
    empty  = 1;
    rd_req = 0;
    #2 rst = 0;
    @(negedge clk);
    do_reset();

    // all requesters held: four-beat rotation
    for (int c = 0; c < 32; c++)
      cycle(1, 4'hF, 0, 1, 0, 1 << ((c / 4) % 4));

    // lone requester re-granted with no gap
    do_reset();
    for (int c = 0; c < 12; c++)
      cycle(1, 4'b0010, 0, 1, 0, 4'b0010);

    // full stall mid-burst
    do_reset();
    for (int c = 0; c < 11; c++)
      cycle(1, 4'b0011, (c >= 2 && c < 5), 1, 0, seq37[c]);

    // owner drops early
    do_reset();
    cycle(1, 4'b0101, 0, 1, 0, 4'b0001);
    cycle(1, 4'b0101, 0, 1, 0, 4'b0001);
    cycle(1, 4'b0100, 0, 1, 0, 0);
    cycle(1, 4'b0100, 0, 1, 0, 4'b0100);

    // reset during third write of requester 3
    do_reset();
    for (int c = 0; c < 14; c++)
      cycle(1, 4'hF, 0, 1, 0, 1 << ((c / 4) % 4));
    cycle(0, 4'hF, 0, 1, 0, 0);
    cycle(1, 4'hF, 0, 1, 0, 4'b0001);

    // read side
    do_reset();
    cycle(1, 0, 0, 0, 1, -1);
    cycle(1, 0, 0, 0, 1, -1);
    cycle(1, 0, 0, 1, 1, -1);
    cycle(1, 0, 0, 1, 1, -1);
    cycle(1, 0, 0, 1, 0, -1);

    for (int c = 0; c < 1500; c++)
      cycle(($urandom_range(99) != 0), N'($urandom),
            ($urandom_range(4) == 0), 1'($urandom),
            1'($urandom), -1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
